// File: rtl/mipi_rx_packet_decoder.sv
// mipi_rx_packet_decoder: CSI-2 packet header decode, short-packet pulses and long-packet payload forwarding.
// Define MIPI_RX_DT_FILTER_EN to forward only RAW10 (DT 0x2B) long packets.
module mipi_rx_packet_decoder (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output logic        output_valid_o,
  output logic [31:0] data_o,
  output logic [5:0]  packet_type_o,
  output logic [1:0]  vc_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic        packet_error_o
);
  typedef enum logic [1:0] {IDLE, PAYLOAD, WAIT_END} state_t;
  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic        dv_prev_q, dv_prev_d;
  logic        ov_q, ov_d;
  logic [31:0] data_q, data_d;
  logic [5:0]  pt_q, pt_d;
  logic [1:0]  vc_q, vc_d;
  logic [3:0]  sp_q, sp_d;
  logic        err_q, err_d;
  logic [5:0]  dt;
  logic [15:0] wc;
  logic        fwd;
  assign dt = data_i[5:0];
  assign wc = {data_i[23:16], data_i[15:8]};
`ifdef MIPI_RX_DT_FILTER_EN
  assign fwd = dt == 6'h2B;
`else
  assign fwd = 1'b1;
`endif
  // A header needs a rising valid edge, so a packet cut by reset is not reparsed mid-stream.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dv_prev_d = data_valid_i;
    ov_d      = 1'b0;
    data_d    = '0;
    pt_d      = pt_q;
    vc_d      = vc_q;
    sp_d      = '0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (data_valid_i && !dv_prev_q) begin
        vc_d = data_i[7:6];
        if (dt <= 6'h0F) begin
          sp_d    = (dt < 6'd4) ? 4'd1 << dt[1:0] : 4'd0;
          state_d = WAIT_END;
        end else begin
          pt_d    = dt;
          rem_d   = wc;
          state_d = (fwd && wc != 16'd0) ? PAYLOAD : WAIT_END;
        end
      end
      PAYLOAD: if (data_valid_i) begin
        ov_d    = 1'b1;
        data_d  = data_i;
        rem_d   = (rem_q > 16'd4) ? rem_q - 16'd4 : 16'd0;
        state_d = (rem_q <= 16'd4) ? WAIT_END : PAYLOAD;
      end else begin
        err_d   = 1'b1;
        rem_d   = '0;
        state_d = IDLE;
      end
      WAIT_END: state_d = data_valid_i ? WAIT_END : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      dv_prev_q <= 1'b1;
      ov_q      <= 1'b0;
      data_q    <= '0;
      pt_q      <= '0;
      vc_q      <= '0;
      sp_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dv_prev_q <= dv_prev_d;
      ov_q      <= ov_d;
      data_q    <= data_d;
      pt_q      <= pt_d;
      vc_q      <= vc_d;
      sp_q      <= sp_d;
      err_q     <= err_d;
    end
  end
  assign output_valid_o = ov_q;
  assign data_o         = data_q;
  assign packet_type_o  = pt_q;
  assign vc_o           = vc_q;
  assign frame_start_o  = sp_q[0];
  assign frame_end_o    = sp_q[1];
  assign line_start_o   = sp_q[2];
  assign line_end_o     = sp_q[3];
  assign packet_error_o = err_q;
endmodule

// File: tb/tb_mipi_rx_packet_decoder.sv
// tb_mipi_rx_packet_decoder: scoreboard bench; stimulus queues expected events, a negedge monitor pops them.
module tb_mipi_rx_packet_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv = 1'b0;
  logic [31:0] di = '0;
  logic        ov, fs, fe, ls, le, err;
  logic [31:0] dout;
  logic [5:0]  pt;
  logic [1:0]  vc;
  int          errors = 0;
  int          checks = 0;
  typedef struct {int kind; logic [31:0] d;} exp_t;
  exp_t sbq[$];
  always #5 clk = ~clk;
  mipi_rx_packet_decoder dut (
    .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(dv), .data_i(di),
    .output_valid_o(ov), .data_o(dout), .packet_type_o(pt), .vc_o(vc),
    .frame_start_o(fs), .frame_end_o(fe), .line_start_o(ls), .line_end_o(le),
    .packet_error_o(err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask
  task automatic push(input int k, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.d = d;
    sbq.push_back(e);
  endtask
  task automatic drive(input logic v, input logic [31:0] d);
    @(posedge clk);
    #1;
    dv = v;
    di = d;
  endtask
  // kind 0 = payload word, 1..4 = FS/FE/LS/LE, 5 = packet error
  task automatic pop_cmp(input int k, input logic [31:0] d);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got kind %0d data %h want nothing", k, d);
    end else begin
      e = sbq.pop_front();
      chk("sb_kind", k, e.kind);
      chk("sb_data", d, e.d);
    end
  endtask
  always @(negedge clk) begin
    logic [4:0] p;
    p = {err, le, ls, fe, fs};
    for (int i = 0; i < 5; i++) if (p[i]) pop_cmp(i + 1, 32'h0);
    if (ov) pop_cmp(0, dout);
    else chk("data_zero_idle", dout, 32'h0);
  end
  task automatic pkt(input logic [31:0] hdr, input int nout, input int ntot, input logic [31:0] seed, input logic trunc);
    logic [31:0] w;
    drive(1'b1, hdr);
    for (int i = 0; i < ntot; i++) begin
      w = seed + i * 32'h01010101;
      if (i < nout) push(0, w);
      drive(1'b1, w);
    end
    if (trunc) push(5, 32'h0);
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
  endtask
  initial begin
    int nf;
    drive(1'b1, 32'hB500_0000);
    drive(1'b1, 32'h1234_5678);
    @(negedge clk);
    chk("rst_ov", {31'b0, ov}, 32'h0);
    chk("rst_pulses", {27'b0, err, le, ls, fe, fs}, 32'h0);
    chk("rst_pt", {26'b0, pt}, 32'h0);
    chk("rst_vc", {30'b0, vc}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dv = 1'b0;
    drive(1'b0, 32'h0);
    push(1, 32'h0);
    pkt(32'hB500_0000, 0, 1, 32'h0, 1'b0);
    chk("fs_vc", {30'b0, vc}, 32'h0);
    push(2, 32'h0);
    pkt(32'h0000_0081, 0, 1, 32'h0, 1'b0);
    chk("fe_vc", {30'b0, vc}, 32'h2);
    push(3, 32'h0);
    pkt(32'h0000_0042, 0, 2, 32'h0, 1'b0);
    chk("ls_vc", {30'b0, vc}, 32'h1);
    push(4, 32'h0);
    pkt(32'h0000_0003, 0, 1, 32'h0, 1'b0);
    pkt(32'h0000_0008, 0, 2, 32'h0, 1'b0);
    chk("short8_vc", {30'b0, vc}, 32'h0);
    pkt(32'hAA00_142B, 5, 6, 32'h1020_3040, 1'b0);
    chk("raw10_pt", {26'b0, pt}, 32'h2B);
    pkt(32'h1100_066B, 2, 4, 32'hA0B0_C0D0, 1'b0);
    chk("partial_vc", {30'b0, vc}, 32'h1);
    pkt(32'h0000_142B, 3, 3, 32'h5566_7788, 1'b1);
    pkt(32'h0000_042C, 1, 2, 32'hDEAD_BEEF, 1'b0);
    chk("after_trunc_pt", {26'b0, pt}, 32'h2C);
`ifdef MIPI_RX_DT_FILTER_EN
    nf = 0;
`else
    nf = 2;
`endif
    pkt(32'h0000_082A, nf, 3, 32'h0F0E_0D0C, 1'b0);
    chk("filter_pt", {26'b0, pt}, 32'h2A);
    pkt(32'h0000_002B, 0, 2, 32'h7777_0000, 1'b0);
    push(0, 32'hC0C0_0001);
    drive(1'b1, 32'h0000_142B);
    drive(1'b1, 32'hC0C0_0001);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    di = 32'hC0C0_0002;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ov", {31'b0, ov}, 32'h0);
    chk("midrst_data", dout, 32'h0);
    chk("midrst_err", {31'b0, err}, 32'h0);
    chk("midrst_pt", {26'b0, pt}, 32'h0);
    rst_n = 1'b1;
    di = 32'hC0C0_0003;
    drive(1'b1, 32'hC0C0_0004);
    drive(1'b1, 32'hC0C0_0005);
    drive(1'b0, 32'h0);
    pkt(32'h0000_082B, 2, 3, 32'h3141_5926, 1'b0);
    chk("post_rst_pt", {26'b0, pt}, 32'h2B);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", sbq.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
